irom_bank: RTL and testbench
============================

// Module: irom_bank
// PURPOSE
//  Instruction memory shared by all cores, directly downstream of the multi-core IMEM arbiter.
//  - Read port: serves the arbiter's rEN/PC_OUT with a registered INS word.
//  - Load port: byte-stream handshake that writes the program image before the cores run.
//  - A load FSM blocks reads until a complete program is present.
// PARAMETERS
//  WIDTH   8    instruction word width; must match the arbiter's WIDTH
//  ADDR_W  8    address width
//  DEPTH   256  words stored; DEPTH <= 2**ADDR_W
// PORTS
//  Clk         in   1        clock; all state updates on posedge
//  Rst_n       in   1        asynchronous active-low reset
//  rEN         in   1        read enable from the IMEM arbiter
//  ADDR        in   ADDR_W   read address from the arbiter's PC_OUT
//  INS         out  WIDTH    registered instruction to the arbiter
//  INS_VALID   out  1        INS holds data for the last accepted read
//  LOAD_START  in   1        one-cycle pulse that starts a program load
//  LOAD_LEN    in   ADDR_W+1 words to load, sampled on LOAD_START; 0 means DEPTH
//  LOAD_DATA   in   WIDTH    load word
//  LOAD_VALID  in   1        LOAD_DATA valid
//  LOAD_READY  out  1        bank accepts a word this cycle
//  LOAD_DONE   out  1        program present; cores may be released
//  PAR_ERR     out  1        parity error on the last read (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, Rst_n=0):
//   - state=EMPTY; INS=0; INS_VALID=0; LOAD_READY=0; LOAD_DONE=0; PAR_ERR=0.
//   - Write pointer and length are cleared; the storage array is not cleared.
//  States:
//   - EMPTY: LOAD_START -> LOADING.
//   - LOADING: ends in RUN after the last word. LOAD_START restarts the load with ptr=0.
//   - RUN: LOAD_START -> LOADING (reload); LOAD_DONE drops in the same cycle.
//  LOADING:
//   - LOAD_READY=1 while ptr < len.
//   - A word is accepted when LOAD_VALID & LOAD_READY: mem[ptr] <= LOAD_DATA, ptr++.
//   - On the last accepted word (ptr==len-1): next state RUN, LOAD_READY=0 next cycle, LOAD_DONE=1 next cycle.
//   - LOAD_LEN > DEPTH is clamped to DEPTH. The pointer never wraps.
//  Read port:
//   - In RUN, when rEN=1 at a posedge, that edge sets INS<=mem[ADDR] and INS_VALID<=1.
//   - Latency is one posedge, so the arbiter's next negedge samples a settled INS.
//   - rEN=0: INS holds its value and INS_VALID<=0.
//   - rEN=1 in EMPTY or LOADING: request ignored, INS unchanged, INS_VALID<=0.
//   - ADDR >= DEPTH: INS<=0 and INS_VALID<=1 (reads as NOP).
//  Simultaneous events:
//   - LOAD_START and LOAD_VALID in the same cycle: only the start takes effect; the word is not written.
//   - LOAD_START in RUN while rEN=1: the read is dropped and INS_VALID<=0.
//  Reset during LOADING: returns to EMPTY. A partial image stays in memory but LOAD_DONE stays 0.
// CONFIGURATION
//  IROM_PARITY_EN defined:
//   - Each word stores an even-parity bit, written on load.
//   - Each read recomputes parity. PAR_ERR<=mismatch, registered with INS. INS_VALID is unaffected.
//  IROM_PARITY_EN undefined:
//   - No parity storage; PAR_ERR is tied to 0.
// STRUCTURE
//  - Shared header irom_defs.vh: state encodings IROM_EMPTY=2'd0, IROM_LOADING=2'd1, IROM_RUN=2'd2; default WIDTH/ADDR_W.
//  - One sub-module, irom_ram: single-port sync RAM, DEPTH x (WIDTH+parity) words.
//    Write port is driven by the load path, read port by the arbiter path. The FSM muxes so only one is active per cycle.
//  - Top level holds the FSM, write pointer, length register and output registers.
// TESTING
//  1. Reset, LOAD_START with LOAD_LEN=4, words 8'h11,22,33,44 with LOAD_VALID held high
//     -> LOAD_READY high for 4 cycles; LOAD_DONE=1 on the cycle after 8'h44.
//  2. After test 1, rEN=1 with ADDR=2 -> INS=8'h33 and INS_VALID=1 after one posedge;
//     rEN=0 -> INS_VALID=0 and INS stays 8'h33.
//  3. rEN=1 with ADDR=0 during LOADING -> INS_VALID=0, INS unchanged.
//  4. Rst_n low after 2 of 4 words, then high -> EMPTY; LOAD_DONE=0; reads give INS_VALID=0.
//  5. In RUN: LOAD_START with LOAD_LEN=0 -> accepts 256 words, then LOAD_DONE;
//     a further LOAD_VALID is not accepted (LOAD_READY=0).
//  6. With IROM_PARITY_EN defined: force a bit flip in stored word 1, read ADDR=1 -> PAR_ERR=1;
//     read ADDR=0 -> PAR_ERR=0.

Source files
------------

// File: rtl/irom_bank_pkg.sv
// irom_bank_pkg: shared definitions for the instruction ROM bank.
// This package holds the load FSM state encodings and the default geometry.
// The geometry must match the upstream IMEM arbiter.
package irom_bank_pkg;

    localparam int IROM_WIDTH  = 8;
    localparam int IROM_ADDR_W = 8;
    localparam int IROM_DEPTH  = 256;

    typedef enum logic [1:0] {
        IROM_EMPTY   = 2'd0,
        IROM_LOADING = 2'd1,
        IROM_RUN     = 2'd2
    } irom_state_t;

endpackage

// File: rtl/irom_bank_ram.sv
// irom_ram: single-port synchronous RAM backing the instruction bank.
// The read data register is cleared on reset, so the bank presents INS=0 out of reset.
// The storage array itself is never cleared.
module irom_ram
    import irom_bank_pkg::*;
#(
    parameter int DATA_W = IROM_WIDTH,
    parameter int ADDR_W = IROM_ADDR_W,
    parameter int DEPTH  = IROM_DEPTH
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage write; no reset, so a partial image survives a reset.
    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read; the register holds its value between reads.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/irom_bank.sv
// irom_bank: instruction memory shared by all cores, fed by the IMEM arbiter.
// A byte-stream load port writes the program image. A load FSM keeps reads blocked until the image is complete.
// Optional feature macro IROM_PARITY_EN: store an even-parity bit per word and flag mismatches on read.
module irom_bank
    import irom_bank_pkg::*;
#(
    parameter int WIDTH  = IROM_WIDTH,
    parameter int ADDR_W = IROM_ADDR_W,
    parameter int DEPTH  = IROM_DEPTH
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              rEN,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [WIDTH-1:0]  INS,
    output logic              INS_VALID,
    input  logic              LOAD_START,
    input  logic [ADDR_W:0]   LOAD_LEN,
    input  logic [WIDTH-1:0]  LOAD_DATA,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    output logic              LOAD_DONE,
    output logic              PAR_ERR
);

`ifdef IROM_PARITY_EN
    localparam int RAM_W = WIDTH + 1;
`else
    localparam int RAM_W = WIDTH;
`endif

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    irom_state_t       r_state;
    irom_state_t       w_next_state;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len_clamped;
    logic              r_ins_valid;
    logic              r_oob;
    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_rd_req;
    logic              w_addr_oob;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [RAM_W-1:0]  w_ram_wdata;
    logic [RAM_W-1:0]  w_ram_rdata;

    assign w_ready    = (r_state == IROM_LOADING) && (r_ptr < r_len);
    assign w_accept   = w_ready && LOAD_VALID && !LOAD_START;
    assign w_last     = (r_ptr == (r_len - ONE_L));
    assign w_rd_req   = (r_state == IROM_RUN) && rEN && !LOAD_START;
    assign w_addr_oob = ({1'b0, ADDR} >= DEPTH_L);
    assign w_ram_addr = (r_state == IROM_LOADING) ? r_ptr[ADDR_W-1:0] : ADDR;

`ifdef IROM_PARITY_EN
    assign w_ram_wdata = {^LOAD_DATA, LOAD_DATA};
    assign PAR_ERR     = !r_oob && (^w_ram_rdata);
`else
    assign w_ram_wdata = LOAD_DATA;
    assign PAR_ERR     = 1'b0;
`endif

    assign INS        = r_oob ? '0 : w_ram_rdata[WIDTH-1:0];
    assign INS_VALID  = r_ins_valid;
    assign LOAD_READY = w_ready;
    assign LOAD_DONE  = (r_state == IROM_RUN);

    // A length of zero, or anything above DEPTH, loads the whole bank.
    always_comb begin
        w_len_clamped = LOAD_LEN;
        if ((LOAD_LEN == '0) || (LOAD_LEN > DEPTH_L)) begin
            w_len_clamped = DEPTH_L;
        end
    end

    // Load FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IROM_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Load FSM next state; LOAD_START wins over everything, including an in-flight load.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IROM_EMPTY: begin
                if (LOAD_START) w_next_state = IROM_LOADING;
            end
            IROM_LOADING: begin
                if (LOAD_START)              w_next_state = IROM_LOADING;
                else if (w_accept && w_last) w_next_state = IROM_RUN;
            end
            IROM_RUN: begin
                if (LOAD_START) w_next_state = IROM_LOADING;
            end
            default: w_next_state = IROM_EMPTY;
        endcase
    end

    // Write pointer and length; a start always rewinds to word zero.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ptr <= '0;
            r_len <= '0;
        end else if (LOAD_START) begin
            r_ptr <= '0;
            r_len <= w_len_clamped;
        end else if (w_accept) begin
            r_ptr <= r_ptr + ONE_L;
        end
    end

    // Read-side qualifiers, registered alongside the RAM read data.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ins_valid <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_ins_valid <= w_rd_req;
            if (w_rd_req) begin
                r_oob <= w_addr_oob;
            end
        end
    end

    irom_ram #(
        .DATA_W (RAM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_we    (w_accept),
        .i_re    (w_rd_req && !w_addr_oob),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_irom_bank.sv
// tb_irom_bank: directed self-checking bench for irom_bank.
// A word-level model of the load/read rules is checked against the DUT on every falling edge.
// Literal expectations pin key values of the model.
// Build with IROM_PARITY_EN defined to also exercise the parity path.
module tb_irom_bank;

    localparam int DEPTH = 256;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       rEN = 1'b0;
    logic [7:0] ADDR = '0;
    logic [7:0] INS;
    logic       INS_VALID;
    logic       LOAD_START = 1'b0;
    logic [8:0] LOAD_LEN = '0;
    logic [7:0] LOAD_DATA = '0;
    logic       LOAD_VALID = 1'b0;
    logic       LOAD_READY;
    logic       LOAD_DONE;
    logic       PAR_ERR;

    int checks = 0;
    int errors = 0;
    int readyCount;
    int flippedAddr = -1;

    // Word-level model of the bank.
    logic [7:0] mMem [DEPTH];
    logic       mLoading = 1'b0;
    logic       mDone = 1'b0;
    int         mIdx = 0;
    int         mLen = 0;
    logic [7:0] mIns = '0;
    logic       mValid = 1'b0;
    logic       mPar = 1'b0;

    irom_bank u_dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .rEN        (rEN),
        .ADDR       (ADDR),
        .INS        (INS),
        .INS_VALID  (INS_VALID),
        .LOAD_START (LOAD_START),
        .LOAD_LEN   (LOAD_LEN),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .LOAD_DONE  (LOAD_DONE),
        .PAR_ERR    (PAR_ERR)
    );

    // Free-running clock with a 10-unit period.
    always #5 Clk = ~Clk;

    function automatic int clampLen(input logic [8:0] l);
        if (l == 9'd0 || int'(l) > DEPTH) return DEPTH;
        return int'(l);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model advances one transaction per rising edge from the sampled inputs.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mLoading <= 1'b0;
            mDone    <= 1'b0;
            mIdx     <= 0;
            mLen     <= 0;
            mIns     <= '0;
            mValid   <= 1'b0;
            mPar     <= 1'b0;
        end else if (LOAD_START) begin
            mLoading <= 1'b1;
            mDone    <= 1'b0;
            mIdx     <= 0;
            mLen     <= clampLen(LOAD_LEN);
            mValid   <= 1'b0;
        end else if (mLoading) begin
            mValid <= 1'b0;
            if (LOAD_VALID && mIdx < mLen) begin
                mMem[mIdx] <= LOAD_DATA;
                mIdx       <= mIdx + 1;
                if (mIdx + 1 == mLen) begin
                    mLoading <= 1'b0;
                    mDone    <= 1'b1;
                end
            end
        end else if (mDone && rEN) begin
            mValid <= 1'b1;
            mIns   <= (int'(ADDR) < DEPTH) ? mMem[ADDR] : 8'h00;
            mPar   <= (int'(ADDR) == flippedAddr);
        end else begin
            mValid <= 1'b0;
        end
    end

    // Compare every DUT output with the model on each falling edge outside reset.
    always @(negedge Clk) begin
        if (Rst_n) begin
            checkOutput("cmp_ins_valid", int'(INS_VALID), int'(mValid));
            checkOutput("cmp_ins", int'(INS), int'(mIns));
            checkOutput("cmp_load_ready", int'(LOAD_READY), int'(mLoading && mIdx < mLen));
            checkOutput("cmp_load_done", int'(LOAD_DONE), int'(mDone));
            checkOutput("cmp_par_err", int'(PAR_ERR), int'(mPar));
        end
    end

    // Drive one cycle of inputs, then return just after the following falling edge.
    task automatic applyStimulus(input logic start, input logic [8:0] len, input logic [7:0] data,
                                 input logic valid, input logic ren, input logic [7:0] addr);
        LOAD_START = start;
        LOAD_LEN   = len;
        LOAD_DATA  = data;
        LOAD_VALID = valid;
        rEN        = ren;
        ADDR       = addr;
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    // Stop the run with a failure if it overruns its time budget.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

        repeat (2) @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("reset_ins", int'(INS), 0);
        checkOutput("reset_valid", int'(INS_VALID), 0);
        checkOutput("reset_ready", int'(LOAD_READY), 0);
        checkOutput("reset_done", int'(LOAD_DONE), 0);
        checkOutput("reset_par", int'(PAR_ERR), 0);

        // Load four words; the word presented with the start must be dropped.
        $display("[TB] test 1: four-word load");
        applyStimulus(1, 9'd4, 8'hEE, 1, 0, 0);
        readyCount = 0;
        for (int i = 0; i < 4; i++) begin
            if (LOAD_READY) readyCount++;
            applyStimulus(0, 0, words[i], 1, 0, 0);
        end
        checkOutput("t1_ready_cycles", readyCount, 4);
        checkOutput("t1_done", int'(LOAD_DONE), 1);
        checkOutput("t1_ready_low", int'(LOAD_READY), 0);

        $display("[TB] test 2: reads in RUN");
        applyStimulus(0, 0, 0, 0, 1, 8'd2);
        checkOutput("t2_ins_addr2", int'(INS), 8'h33);
        checkOutput("t2_valid", int'(INS_VALID), 1);
        applyStimulus(0, 0, 0, 0, 0, 8'd2);
        checkOutput("t2_idle_valid", int'(INS_VALID), 0);
        checkOutput("t2_idle_ins", int'(INS), 8'h33);
        applyStimulus(0, 0, 0, 0, 1, 8'd0);
        checkOutput("t2_ins_addr0", int'(INS), 8'h11);

        // A reload start that coincides with a read drops that read.
        $display("[TB] test 3: reads during LOADING");
        applyStimulus(1, 9'd4, 0, 0, 1, 8'd1);
        checkOutput("t3_start_valid", int'(INS_VALID), 0);
        checkOutput("t3_start_ins", int'(INS), 8'h11);
        checkOutput("t3_done_drop", int'(LOAD_DONE), 0);
        applyStimulus(0, 0, 8'h55, 1, 1, 8'd0);
        applyStimulus(0, 0, 8'h66, 1, 1, 8'd0);
        checkOutput("t3_load_valid", int'(INS_VALID), 0);
        checkOutput("t3_load_ins", int'(INS), 8'h11);

        $display("[TB] test 4: reset mid-load");
        Rst_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        #1;
        checkOutput("t4_rst_ins", int'(INS), 0);
        checkOutput("t4_rst_done", int'(LOAD_DONE), 0);
        checkOutput("t4_rst_ready", int'(LOAD_READY), 0);
        Rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 8'd0);
        checkOutput("t4_read_valid", int'(INS_VALID), 0);
        checkOutput("t4_read_done", int'(LOAD_DONE), 0);

        // Get back to RUN, then reload the whole bank with a zero length.
        $display("[TB] test 5: full-depth load");
        applyStimulus(1, 9'd2, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h77, 1, 0, 0);
        applyStimulus(0, 0, 8'h88, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'd1);
        checkOutput("t5_short_ins", int'(INS), 8'h88);
        applyStimulus(1, 9'd0, 0, 0, 0, 0);
        readyCount = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LOAD_READY) readyCount++;
            applyStimulus(0, 0, 8'(i) ^ 8'h5A, 1, 0, 0);
        end
        checkOutput("t5_ready_cycles", readyCount, 256);
        checkOutput("t5_done", int'(LOAD_DONE), 1);
        checkOutput("t5_ready_low", int'(LOAD_READY), 0);
        applyStimulus(0, 0, 8'hFF, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 8'd0);
        checkOutput("t5_ins_addr0", int'(INS), 8'h5A);
        applyStimulus(0, 0, 0, 0, 1, 8'd255);
        checkOutput("t5_ins_addr255", int'(INS), 8'hA5);

        // An oversize length clamps to the bank depth.
        $display("[TB] test 5b: oversize length");
        applyStimulus(1, 9'd300, 0, 0, 0, 0);
        readyCount = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (LOAD_READY) readyCount++;
            applyStimulus(0, 0, ~8'(i), 1, 0, 0);
        end
        checkOutput("t5b_ready_cycles", readyCount, 256);
        checkOutput("t5b_done", int'(LOAD_DONE), 1);
        applyStimulus(0, 0, 0, 0, 1, 8'd3);
        checkOutput("t5b_ins_addr3", int'(INS), 8'hFC);

`ifdef IROM_PARITY_EN
        // Corrupt the stored parity bit of word 1; its data bits stay intact.
        $display("[TB] test 6: parity error injection");
        u_dut.u_ram.r_mem[1][8] = ~u_dut.u_ram.r_mem[1][8];
        flippedAddr = 1;
        applyStimulus(0, 0, 0, 0, 1, 8'd1);
        checkOutput("t6_par_err_addr1", int'(PAR_ERR), 1);
        checkOutput("t6_valid_addr1", int'(INS_VALID), 1);
        checkOutput("t6_ins_addr1", int'(INS), 8'hFE);
        applyStimulus(0, 0, 0, 0, 1, 8'd0);
        checkOutput("t6_par_ok_addr0", int'(PAR_ERR), 0);
`endif

        applyStimulus(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
